ecg_sample_uart_tx: RTL and testbench

Buffers signed 16-bit filtered ECG samples from the FIR filter output and serialises them over an 8N1 UART line, so an off-chip host can capture and compare filter-order results. It sits at the downstream end of the filter sample interface: the filter writes one sample per enable, and this block queues the samples and transmits them byte-wise. The transmit path is a small FIFO, a byte sequencer and a bit-level UART FSM.

---
 rtl/ecg_sample_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_ecg_sample_uart_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_sample_uart_tx.sv
// Queues signed 16-bit filter samples and sends them as 8N1 bytes (high byte first); define SYNC_HEADER_EN to prefix each sample with 0xA5.
// Latency: sample accepted at edge N is popped at N+1, tx start bit begins at N+2.
// Backpressure: sample_ready drops when the FIFO is full; samples offered then are discarded and overflow sticks.
module ecg_sample_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
`ifdef SYNC_HEADER_EN
    localparam logic [1:0] LAST_BYTE = 2'd2;
`else
    localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Sample FIFO
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             fifo_full, fifo_empty, push, pop;
    logic [15:0]      rd_dat;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign push       = sample_valid & ~fifo_full;
    assign rd_dat     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    logic overflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (sample_valid && fifo_full) overflow_q <= 1'b1;
        end
    end

    // Byte / bit sequencer
    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [15:0]      shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_done;
    logic [7:0]       cur_byte;

    assign bit_done = (baud_q == BAUD_LAST);

    always_comb begin
`ifdef SYNC_HEADER_EN
        case (byte_idx_q)
            2'd0:    cur_byte = 8'hA5;
            2'd1:    cur_byte = shift_q[15:8];
            default: cur_byte = shift_q[7:0];
        endcase
`else
        cur_byte = (byte_idx_q == 2'd0) ? shift_q[15:8] : shift_q[7:0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = rd_dat;
                    byte_idx_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_START;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next sample's start bit.
                        pop        = 1'b1;
                        shift_d    = rd_dat;
                        byte_idx_d = '0;
                        state_d    = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q == S_IDLE || bit_done) baud_d = '0;
        else                               baud_d = baud_q + CNT_W'(1);
    end

    // tx and busy are registered from the current state, so both lag it by one cycle together.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte[bit_idx_q];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE) || !fifo_empty;
    end

    assign sample_ready = ~fifo_full;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;
    assign fifo_level   = count_q;

endmodule

// File: tb/tb_ecg_sample_uart_tx.sv
// Bench for ecg_sample_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=16; a line monitor decodes tx into bytes.
module tb_ecg_sample_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef SYNC_HEADER_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, tx, busy, overflow;
    logic [4:0]  fifo_level;

    ecg_sample_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .tx(tx), .busy(busy), .overflow(overflow),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] exp_q[$];
    int         frame_err = 0;
    int         n_vec = 0;
    int         n_err = 0;

    // UART receiver: samples each bit near its centre on falling clock edges.
    initial begin : line_monitor
        logic [7:0] b;
        logic       st, sp, ab;
        int         t0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                t0 = cyc;
                ab = 1'b0;
                repeat (CPB/2 - 1) @(negedge clk);
                ab = ab | reset;
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    ab = ab | reset;
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                ab = ab | reset;
                sp = tx;
                if (!ab) begin
                    if (st !== 1'b0 || sp !== 1'b1) frame_err++;
                    rx_q.push_back(b);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_bytes(input int n, input int bound);
        int g;
        g = 0;
        while (rx_q.size() < n && g < bound) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic compare_rx();
        logic [31:0] act;
        int gap_bad;
        chk("rx_byte_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD;
            chk($sformatf("rx_byte%0d", i), act, {24'h0, exp_q[i]});
        end
        gap_bad = 0;
        for (int i = 1; i < rx_t.size(); i++)
            if (rx_t[i] - rx_t[i-1] != 10*CPB) gap_bad++;
        chk("byte_gap_violations", gap_bad, 0);
    endtask

    task automatic push_exp(input logic [15:0] s);
`ifdef SYNC_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
    endtask

    // One sample from an idle line: latency, busy duration and decoded bytes.
    task automatic run_vector(input logic [15:0] smp, input logic [7:0] hi, input logic [7:0] lo);
        int lat, t_fall, g;
        clear_rx();
`ifdef SYNC_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        sample_in    = smp;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        lat = 0;
        while (tx !== 1'b0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("tx_fall_latency", lat, 2);
        t_fall = cyc;
        g = 0;
        while (busy !== 1'b0 && g < NB*10*CPB + 50) begin
            @(negedge clk);
            g++;
        end
        chk("busy_duration", cyc - t_fall, NB*10*CPB);
        wait_bytes(NB, 100);
        compare_rx();
        chk("overflow_clear", overflow, 1'b0);
        repeat (5) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] smp;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    vec_t vt[6];

    initial begin : main
        int lows, busys, g;
        logic [15:0] s;

        vt[0] = '{16'h1234, 8'h12, 8'h34};
        vt[1] = '{16'h8001, 8'h80, 8'h01};
        vt[2] = '{16'h00FF, 8'h00, 8'hFF};
        vt[3] = '{16'hFFFF, 8'hFF, 8'hFF};
        vt[4] = '{16'h0000, 8'h00, 8'h00};
        vt[5] = '{16'hA55A, 8'hA5, 8'h5A};

        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        chk("reset_ready", sample_ready, 1'b1);
        chk("reset_level", fifo_level, 0);
        reset = 1'b0;

        lows = 0;
        busys = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        chk("idle_tx_not_high_cycles", lows, 0);
        chk("idle_busy_cycles", busys, 0);

        for (int v = 0; v < 6; v++) run_vector(vt[v].smp, vt[v].hi, vt[v].lo);

        // Burst of DEPTH+2 samples on consecutive cycles.
        clear_rx();
        for (int k = 0; k < DEPTH + 2; k++) begin
            s = {8'(k) + 8'h10, 8'hF0 - 8'(k)};
            sample_in    = s;
            sample_valid = 1'b1;
            chk($sformatf("burst_ready%0d", k), sample_ready, (k < DEPTH + 1) ? 1'b1 : 1'b0);
            if (k < DEPTH + 1) push_exp(s);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        chk("burst_overflow", overflow, 1'b1);
        chk("burst_level", fifo_level, DEPTH);
        wait_bytes((DEPTH + 1)*NB, (DEPTH + 1)*NB*10*CPB + 200);
        compare_rx();
        chk("burst_overflow_sticky", overflow, 1'b1);
        g = 0;
        while (busy !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("burst_busy_end", busy, 1'b0);

        // Push coinciding with the pop at the end of the first sample, level 3.
        clear_rx();
        for (int k = 0; k < 4; k++) begin
            s = 16'h3C00 + 16'(k*16'h0111);
            sample_in    = s;
            sample_valid = 1'b1;
            push_exp(s);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        chk("pp_level_after_fill", fifo_level, 3);
        repeat (NB*10*CPB - 3) @(negedge clk);
        chk("pp_level_before", fifo_level, 3);
        s = 16'hC0DE;
        sample_in    = s;
        sample_valid = 1'b1;
        push_exp(s);
        @(negedge clk);
        sample_valid = 1'b0;
        chk("pp_level_same_cycle", fifo_level, 3);
        @(negedge clk);
        chk("pp_level_after", fifo_level, 3);
        wait_bytes(5*NB, 5*NB*10*CPB + 200);
        compare_rx();
        g = 0;
        while (busy !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end

        // Reset in the middle of the second byte's data bits (bit 4 of 0xEF is 0).
        clear_rx();
        for (int k = 0; k < 3; k++) begin
            sample_in    = (k == 0) ? 16'hEFEF : 16'h1111;
            sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        chk("rst_start_bit", tx, 1'b0);
        repeat (61) @(negedge clk);
        chk("rst_pre_tx", tx, 1'b0);
        chk("rst_pre_overflow", overflow, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", sample_ready, 1'b1);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        clear_rx();
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("post_rst_tx_low_cycles", lows, 0);
        chk("post_rst_rx_bytes", rx_q.size(), 0);
        chk("post_rst_busy", busy, 1'b0);
        run_vector(16'h00FF, 8'h00, 8'hFF);

        chk("frame_errors", frame_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
